sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_acc_pkg.sv | 12 +
 rtl/sum_accumulator.sv | 102 ++++++++++
 tb/tb_sum_accumulator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types for the windowed sum accumulator: FSM state encoding and count width.
// Imported by sum_accumulator.
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sum_accumulator.sv
// Sums WINDOW unsigned samples (or fewer on flush) and presents the total with count and overflow flag.
// Latency: result valid 1 cycle after the closing accept; held until out_valid && out_ready.
// Backpressure: in_ready drops while a result is held; SUM_ACC_SAT_EN selects saturating vs wrapping totals.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WINDOW = 8,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic               accept;
    logic               last;

    assign accept  = in_valid && (state == ACCUM);
    assign last    = (cnt == CNT_W'(WINDOW - 1));
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign carry   = sum_ext[ACC_W];

    // Once clamped, further adds carry again (or add zero), so all-ones persists for the window.
`ifdef SUM_ACC_SAT_EN
    assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (accept && (last || flush)) begin
                    state_nxt = HOLD;
                end else if (!accept && flush && (cnt != '0)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        out_sum   = acc;
        out_count = cnt;
        out_ovf   = ovf;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end else if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized and directed checks of sum_accumulator against a window-of-samples reference model.
module tb_sum_accumulator;
    import sum_acc_pkg::*;

    localparam int DATA_W = 8;
    localparam int WINDOW = 8;
    localparam int ACC_W  = 10;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: samples accepted into the open window, and whether a result is pending.
    int q[$];
    bit m_hold = 1'b0;

    sum_accumulator #(.DATA_W(DATA_W), .WINDOW(WINDOW), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int total();
        int t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    function automatic int exp_sum();
`ifdef SUM_ACC_SAT_EN
        return (total() > ACC_MAX) ? ACC_MAX : total();
`else
        return total() % (ACC_MAX + 1);
`endif
    endfunction

    function automatic int exp_ovf();
        return (total() > ACC_MAX) ? 1 : 0;
    endfunction

    // Check current outputs against the model, then drive one cycle of inputs and advance the model.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic fl, input logic ordy);
        @(negedge clk);
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
        if (m_hold) begin
            check("out_sum", out_sum, exp_sum());
            check("out_count", out_count, q.size());
            check("out_ovf", out_ovf, exp_ovf());
        end
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        if (!m_hold) begin
            if (iv) begin
                q.push_back(int'(d));
                if (q.size() == WINDOW || fl) m_hold = 1'b1;
            end else if (fl && q.size() > 0) begin
                m_hold = 1'b1;
            end
        end else if (ordy) begin
            m_hold = 1'b0;
            q.delete();
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        reset = 1'b1;

        // Eight samples of 10 back-to-back.
        for (int i = 0; i < WINDOW; i++) step(1'b1, 8'd10, 1'b0, 1'b1);
        settle();
        check("t34_valid", out_valid, 1);
        check("t34_sum", out_sum, 80);
        check("t34_count", out_count, 8);
        check("t34_ovf", out_ovf, 0);
        drain();

        // Partial window closed by a lone flush, then flush on an empty window.
        step(1'b1, 8'd4, 1'b0, 1'b1);
        step(1'b1, 8'd7, 1'b0, 1'b1);
        step(1'b1, 8'd11, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        settle();
        check("t35_sum", out_sum, 22);
        check("t35_count", out_count, 3);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        settle();
        check("t35_empty_flush", out_valid, 0);
        drain();

        // Stall in HOLD with upstream pushing, then resume.
        for (int i = 0; i < WINDOW; i++) step(1'b1, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'd99, 1'b0, 1'b0);
        settle();
        check("t36_held_sum", out_sum, 24);
        check("t36_in_ready", in_ready, 0);
        step(1'b1, 8'd99, 1'b0, 1'b1);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 8'd5, 1'b0, 1'b1);
        settle();
        check("t36_new_sum", out_sum, 40);
        drain();

        // Overflow on eight samples of 255.
        for (int i = 0; i < WINDOW; i++) step(1'b1, 8'd255, 1'b0, 1'b1);
        settle();
`ifdef SUM_ACC_SAT_EN
        check("t37_sum", out_sum, 1023);
`else
        check("t37_sum", out_sum, 1016);
`endif
        check("t37_ovf", out_ovf, 1);
        drain();

        // Asynchronous reset mid-window.
        for (int i = 0; i < 5; i++) step(1'b1, 8'd9, 1'b0, 1'b1);
        #2;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("t38_rst_valid", out_valid, 0);
        check("t38_rst_ready", in_ready, 1);
        check("t38_rst_sum", out_sum, 0);
        check("t38_rst_count", out_count, 0);
        check("t38_rst_ovf", out_ovf, 0);
        q.delete();
        m_hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < WINDOW; i++) step(1'b1, 8'd1, 1'b0, 1'b1);
        settle();
        check("t38_sum", out_sum, 8);
        drain();

        // Flush coincident with the second accept.
        step(1'b1, 8'd4, 1'b0, 1'b1);
        step(1'b1, 8'd17, 1'b1, 1'b1);
        settle();
        check("t39_sum", out_sum, 21);
        check("t39_count", out_count, 2);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 DATA_W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
